vga_fill_ctrl: RTL and testbench
================================

VGA_FILL_CTRL -- requirements
Module: vga_fill_ctrl

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 The block SHALL have parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 The block SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request to fill a rectangle, sampled only in IDLE.
REQ-006 The block SHALL have port clear  input  1  request to fill the whole screen with colour 0, sampled only in IDLE.
REQ-007 The block SHALL have port x0  input  8  rectangle left column.
REQ-008 The block SHALL have port y0  input  7  rectangle top row.
REQ-009 The block SHALL have port w  input  8  rectangle width minus 1.
REQ-010 The block SHALL have port h  input  7  rectangle height minus 1.
REQ-011 The block SHALL have port colour_in  input  3  fill colour.
REQ-012 The block SHALL have port x  output  8  VGA pixel column, registered.
REQ-013 The block SHALL have port y  output  7  VGA pixel row, registered.
REQ-014 The block SHALL have port colour  output  3  VGA pixel colour, registered.
REQ-015 The block SHALL have port plot  output  1  pixel write strobe, registered.
REQ-016 The block SHALL have port busy  output  1  high while a fill is in progress.
REQ-017 The block SHALL have port done  output  1  one-cycle pulse when a fill completes.

Function
REQ-018 The block SHALL implement states IDLE, DRAW and DONE.
REQ-019 In IDLE, clear=1 SHALL latch origin (0,0), extents (SCREEN_W-1, SCREEN_H-1) and colour 0, then enter DRAW; clear SHALL take priority over a simultaneous start.
REQ-020 In IDLE with clear=0 and start=1, the block SHALL latch x0, y0, w, h and colour_in, then enter DRAW; inputs changing afterwards SHALL NOT affect the fill in progress.
REQ-021 In DRAW, the block SHALL visit exactly one pixel per cycle in raster order: column offset 0..w fastest, then row offset 0..h.
REQ-022 The first pixel SHALL appear on x/y/colour in the cycle after the accepting edge; a fill SHALL occupy exactly N=(w+1)*(h+1) consecutive DRAW cycles.
REQ-023 Pixel coordinates SHALL be computed as x0+col and y0+row with 9-bit and 8-bit intermediates so that no wrap-around occurs.
REQ-024 plot SHALL be 1 for a visited pixel only if its column is < SCREEN_W and its row is < SCREEN_H; otherwise plot SHALL be 0 (clipping) while traversal still advances.
REQ-025 busy SHALL be 1 in every DRAW cycle and 0 in IDLE and DONE.
REQ-026 After the last pixel, the block SHALL enter DONE for exactly one cycle with done=1 and plot=0, then return to IDLE.
REQ-027 start and clear SHALL be ignored in DRAW and DONE; they are not queued.
REQ-028 Outside DRAW, plot SHALL be 0, and x, y and colour SHALL hold their last values.

Reset
REQ-029 When resetn=0 at a rising edge, the block SHALL enter IDLE with x=0, y=0, colour=0, plot=0, busy=0, done=0 and all counters cleared.
REQ-030 Reset asserted mid-fill SHALL abort the fill immediately, with no done pulse, and plot SHALL be 0 from the next cycle.

Verification
REQ-031 The bench SHALL drive start with x0=10, y0=5, w=2, h=1, colour_in=3: six plot pulses at (10,5)(11,5)(12,5)(10,6)(11,6)(12,6), all with colour 3, busy high for 6 cycles, done pulse in cycle 7.
REQ-032 The bench SHALL drive clear=1 and start=1 together: 19200 plot pulses with colour 0 covering (0,0)..(159,119); last pixel (159,119); single done pulse.
REQ-033 The bench SHALL drive start with x0=158, y0=119, w=3, h=1: 8 DRAW cycles, plot=1 only at (158,119) and (159,119), done after cycle 8.
REQ-034 The bench SHALL drive start with w=0, h=0 at (0,0): exactly one plot pulse at (0,0), busy high for 1 cycle, done on the next cycle.
REQ-035 The bench SHALL pulse start again during DRAW and in the DONE cycle: both are ignored and the pixel sequence and count are unchanged.
REQ-036 The bench SHALL assert resetn=0 after 3 pixels of a 4x4 fill: next cycle plot=0, busy=0, done=0 and all outputs zero; a new start is then accepted normally.

Source files
------------

// File: rtl/vga_fill_ctrl.sv
// Rectangle / full-screen fill engine for a VGA pixel-write port.
// Walks the rectangle in raster order, one pixel per clock, and drops plot for off-screen pixels.
module vga_fill_ctrl #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       start,
   input  logic       clear,
   input  logic [7:0] x0,
   input  logic [6:0] y0,
   input  logic [7:0] w,
   input  logic [6:0] h,
   input  logic [2:0] colour_in,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   // state  | meaning
   // IDLE   | waiting for start/clear; outputs hold, plot low
   // DRAW   | one pixel presented per cycle, busy high
   // DONE   | single-cycle done pulse, then back to IDLE
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0] r_state;
   logic [7:0] r_x0;
   logic [6:0] r_y0;
   logic [7:0] r_w;
   logic [6:0] r_h;
   logic [7:0] r_col_off;
   logic [6:0] r_row_off;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [2:0] r_colour;
   logic       r_plot;

   logic       w_accept;
   logic       w_wrap;
   logic       w_last;
   logic [7:0] w_acc_x0;
   logic [6:0] w_acc_y0;
   logic [7:0] w_acc_w;
   logic [6:0] w_acc_h;
   logic [2:0] w_acc_c;
   logic [7:0] w_org_x;
   logic [6:0] w_org_y;
   logic [7:0] w_off_x;
   logic [6:0] w_off_y;
   logic [7:0] w_nx_col;
   logic [6:0] w_nx_row;
   logic [8:0] w_px;
   logic [7:0] w_py;
   logic       w_vis;

   always_comb begin
      w_accept = (r_state == S_IDLE) && (start || clear);
      w_wrap   = (r_col_off == r_w);
      w_last   = w_wrap && (r_row_off == r_h);
      w_nx_col = w_wrap ? 8'd0 : r_col_off + 8'd1;
      w_nx_row = w_wrap ? r_row_off + 7'd1 : r_row_off;

      // clear wins over start and paints the whole visible area with colour 0
      w_acc_x0 = clear ? 8'd0 : x0;
      w_acc_y0 = clear ? 7'd0 : y0;
      w_acc_w  = clear ? 8'(SCREEN_W - 1) : w;
      w_acc_h  = clear ? 7'(SCREEN_H - 1) : h;
      w_acc_c  = clear ? 3'd0 : colour_in;

      w_org_x = r_x0;
      w_org_y = r_y0;
      w_off_x = w_nx_col;
      w_off_y = w_nx_row;
      if (r_state == S_IDLE) begin
         w_org_x = w_acc_x0;
         w_org_y = w_acc_y0;
         w_off_x = 8'd0;
         w_off_y = 7'd0;
      end

      // widened sums so far-right/bottom pixels clip instead of wrapping on-screen
      w_px  = {1'b0, w_org_x} + {1'b0, w_off_x};
      w_py  = {1'b0, w_org_y} + {1'b0, w_off_y};
      w_vis = (w_px < 9'(SCREEN_W)) && (w_py < 8'(SCREEN_H));
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_x0      <= '0;
         r_y0      <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_col_off <= '0;
         r_row_off <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_colour  <= '0;
         r_plot    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_plot <= 1'b0;
               if (w_accept) begin
                  r_x0      <= w_acc_x0;
                  r_y0      <= w_acc_y0;
                  r_w       <= w_acc_w;
                  r_h       <= w_acc_h;
                  r_col_off <= '0;
                  r_row_off <= '0;
                  r_x       <= w_px[7:0];
                  r_y       <= w_py[6:0];
                  r_colour  <= w_acc_c;
                  r_plot    <= w_vis;
                  r_state   <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (w_last) begin
                  r_plot  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_col_off <= w_nx_col;
                  r_row_off <= w_nx_row;
                  r_x       <= w_px[7:0];
                  r_y       <= w_py[6:0];
                  r_plot    <= w_vis;
               end
            end
            S_DONE: begin
               r_plot  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_plot  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign x      = r_x;
   assign y      = r_y;
   assign colour = r_colour;
   assign plot   = r_plot;
   assign busy   = (r_state == S_DRAW);
   assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Scoreboard bench for vga_fill_ctrl: fills are expanded into expected pixel queues by a
// plain nested-loop model; a negedge monitor pops and compares every plotted pixel.
module tb_vga_fill_ctrl;

   localparam int SW    = 160;
   localparam int SH    = 120;
   localparam int LIMIT = 40000;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic       start;
   logic       clear;
   logic [7:0] x0;
   logic [6:0] y0;
   logic [7:0] w;
   logic [6:0] h;
   logic [2:0] colour_in;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   int vectors   = 0;
   int miscomp   = 0;
   logic [17:0] exp_q[$];

   vga_fill_ctrl #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .start    (start),
      .clear    (clear),
      .x0       (x0),
      .y0       (y0),
      .w        (w),
      .h        (h),
      .colour_in(colour_in),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .plot     (plot),
      .busy     (busy),
      .done     (done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscomp++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // monitor: every plot strobe must match the head of the expected queue
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge CLOCK_50);
         if (plot === 1'b1) begin
            chk("plot_while_busy", int'(busy), 1);
            vectors++;
            if (exp_q.size() == 0) begin
               miscomp++;
               $display("FAIL unexpected_pixel: got (%0d,%0d) c%0d, expected no pixel", x, y, colour);
            end else begin
               e = exp_q.pop_front();
               if ({x, y, colour} !== e) begin
                  miscomp++;
                  $display("FAIL pixel: got (%0d,%0d) c%0d, expected (%0d,%0d) c%0d",
                           x, y, colour, e[17:10], e[9:3], e[2:0]);
               end
            end
         end
      end
   end

   task automatic randomize_inputs();
      x0        = 8'($urandom);
      y0        = 7'($urandom);
      w         = 8'($urandom);
      h         = 7'($urandom);
      colour_in = 3'($urandom);
   endtask

   task automatic run_fill(input bit use_clear, input bit use_start, input int ax0, input int ay0,
                           input int aw, input int ah, input int ac, input bit poke);
      int ex0, ey0, ew, eh, ec, n, cnt;
      if (use_clear) begin
         ex0 = 0; ey0 = 0; ew = SW - 1; eh = SH - 1; ec = 0;
      end else begin
         ex0 = ax0; ey0 = ay0; ew = aw; eh = ah; ec = ac;
      end
      for (int r = 0; r <= eh; r++)
         for (int c = 0; c <= ew; c++)
            if (ex0 + c < SW && ey0 + r < SH)
               exp_q.push_back({8'(ex0 + c), 7'(ey0 + r), 3'(ec)});
      n = (ew + 1) * (eh + 1);

      start = use_start; clear = use_clear;
      x0 = 8'(ax0); y0 = 7'(ay0); w = 8'(aw); h = 7'(ah); colour_in = 3'(ac);
      @(negedge CLOCK_50);
      start = 1'b0; clear = 1'b0;
      randomize_inputs();
      cnt = 0;
      while (busy === 1'b1 && cnt < LIMIT) begin
         cnt++;
         if (poke && cnt == 2) begin start = 1'b1; randomize_inputs(); end
         if (poke && cnt == 3) start = 1'b0;
         @(negedge CLOCK_50);
      end
      chk("busy_cycles", cnt, n);
      chk("done_pulse", int'(done), 1);
      chk("plot_in_done", int'(plot), 0);
      chk("queue_drained", exp_q.size(), 0);
      if (poke) start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      chk("done_cleared", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      @(negedge CLOCK_50);
      chk("idle_stays", int'(busy), 0);
      exp_q.delete();
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; clear = 1'b0;
      x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      resetn = 1'b1;
      @(negedge CLOCK_50);

      run_fill(0, 1, 10, 5, 2, 1, 3, 0);
      run_fill(1, 1, 77, 33, 4, 4, 5, 0);
      run_fill(0, 1, 158, 119, 3, 1, 6, 0);
      run_fill(0, 1, 0, 0, 0, 0, 7, 0);
      run_fill(0, 1, 40, 50, 5, 2, 2, 1);
      run_fill(0, 1, 150, 100, 20, 30, 1, 1);

      for (int i = 0; i < 25; i++) begin
         bit cl;
         cl = ($urandom_range(0, 7) == 0);
         run_fill(cl, !cl || ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 255), $urandom_range(0, 127),
                  $urandom_range(0, 12), $urandom_range(0, 6),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      end

      // abort a 4x4 fill after three pixels
      exp_q.push_back({8'd20, 7'd30, 3'd4});
      exp_q.push_back({8'd21, 7'd30, 3'd4});
      exp_q.push_back({8'd22, 7'd30, 3'd4});
      start = 1'b1; x0 = 8'd20; y0 = 7'd30; w = 8'd3; h = 7'd3; colour_in = 3'd4;
      @(negedge CLOCK_50);
      start = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b0;
      @(negedge CLOCK_50);
      chk("abort_plot", int'(plot), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_x", int'(x), 0);
      chk("abort_y", int'(y), 0);
      chk("abort_colour", int'(colour), 0);
      resetn = 1'b1;
      chk("abort_pixels_seen", exp_q.size(), 0);
      exp_q.delete();
      @(negedge CLOCK_50);
      run_fill(0, 1, 3, 4, 1, 1, 5, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
      $finish;
   end

endmodule
